encode_8b10b_lanes: RTL and testbench

Parametrised multi-lane IBM 8b/10b encoder. It encodes LANES bytes per word, chaining running disparity (RD) from lane 0 up to lane LANES-1, and holds RD across words. It sits between the framing logic and the serializer. Input words are accepted on a valid/ready handshake into a 2-entry buffer. Output words are pulled by the serializer's nextword_enable strobe, and a K28.5 idle word is emitted whenever the buffer is empty.

---
 rtl/encode_8b10b_lanes.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_encode_8b10b_lanes.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/encode_8b10b_lanes.sv
// Multi-lane IBM 8b/10b encoder.
// A 2-entry buffer sits between the framing logic (valid/ready) and the
// serializer (nextword_enable pull). Each pulled word is encoded lane by lane.
// Running disparity is chained from lane 0 to lane LANES-1 and carried across words.
// An empty buffer produces an all-K28.5 idle word.
//
// Optional build macro ENC8B10B_KCHAR_EN enables control characters via in_k.
// Without it, in_k is ignored, every lane is encoded as data and k_err is held at 0.
//
// Handshake: a word is accepted on any clk edge where in_valid && in_ready.
// in_ready is registered. It never depends combinationally on in_valid.
// A word is popped on any clk edge where nextword_enable is high and the buffer is non-empty.
// d_out/idle_out/k_err/rd_out update one clk after the strobe and otherwise hold.
module encode_8b10b_lanes #(
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  nextword_enable,
  output logic [10*LANES-1:0]   d_out,
  output logic                  idle_out,
  output logic                  k_err,
  output logic                  rd_out
);

  localparam int EW = 9*LANES;   // buffer entry: {k flags, data bytes}

  // ---------------------------------------------------------------------
  // Code tables, written MSB-first in transmission order (abcdei / fghj),
  // RD- column only. The RD+ column is the bitwise complement where it differs.
  // ---------------------------------------------------------------------
  function automatic logic [5:0] code6(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      default: c = 6'b101011;   // D.31
    endcase
    return c;
  endfunction

  // Data 3b/4b, primary D.x.P7 for y=7 (the A7 choice is made by the caller)
  function automatic logic [3:0] code4d(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // K28.y 3b/4b. Every K column pair is complementary, including balanced ones.
  function automatic logic [3:0] code4k(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b0110;
      3'd2: c = 4'b1010;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b0101;
      3'd6: c = 4'b1001;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  // Tables are written a..i / f..j MSB-first. Bit 0 of d_out is 'a', so reverse them.
  function automatic logic [5:0] rev6(input logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // One lane: returns {k_bad, rd_after, code[9:0]} with code bit 0 = 'a'.
  function automatic logic [11:0] enc_lane(input logic [7:0] byte_in,
                                           input logic       is_k,
                                           input logic       rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic       k_bad;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       bal6;
    logic       bal4;
    logic       rd6;
    logic       rd4;
    logic       a7;
    x     = byte_in[4:0];
    y     = byte_in[7:5];
    k_ok  = (x == 5'd28) ||
            ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                             (x == 5'd29) || (x == 5'd30)));
    k_bad = is_k && !k_ok;
    // An unsupported K request degrades to K28.5 so the line stays comma-legal
    if (k_bad) begin
      x = 5'd28;
      y = 3'd5;
    end
    // 5b/6b sub-block
    if (is_k && (x == 5'd28)) c6 = 6'b001111;
    else                      c6 = code6(x);
    bal6 = ($countones(c6) == 3);
    if (rd_in && (!bal6 || (x == 5'd7))) c6 = ~c6;
    rd6 = rd_in ^ !bal6;
    // 3b/4b sub-block, selected by the RD left by the 6b sub-block
    if (is_k) begin
      c4   = (x == 5'd28) ? code4k(y) : 4'b0111;
      bal4 = ($countones(c4) == 2);
      if (rd6) c4 = ~c4;
    end else begin
      // A7 avoids a run of five equal bits across the sub-block boundary
      a7   = (y == 3'd7) &&
             ((!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
      c4   = a7 ? 4'b0111 : code4d(y);
      bal4 = ($countones(c4) == 2);
      if (rd6 && (!bal4 || (y == 3'd3))) c4 = ~c4;
    end
    rd4 = rd6 ^ !bal4;
    return {k_bad, rd4, rev4(c4), rev6(c6)};
  endfunction

  // ---------------------------------------------------------------------
  // Input buffer
  // ---------------------------------------------------------------------
  logic [EW-1:0]        fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic [EW-1:0]        head;
  logic [8*LANES-1:0]   head_data;
  logic [LANES-1:0]     head_k;
  logic [LANES-1:0]     lane_k;

  assign push      = in_valid && in_ready;
  assign empty     = (count == 2'd0);
  assign pop       = nextword_enable && !empty;
  assign head      = fifo_mem[rd_ptr];
  assign head_k    = head[EW-1 -: LANES];
  assign head_data = head[8*LANES-1:0];

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel out
  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  // Buffer storage: only the pointer/count carry reset state
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_k, in_data};
  end

  // Buffer pointers, occupancy and the registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
    end
  end

  // ---------------------------------------------------------------------
  // Lane encoding chain
  // ---------------------------------------------------------------------
  logic                 rd;
  logic [10*LANES-1:0]  enc_code;
  logic                 enc_rd;
  logic                 enc_kerr;
  logic                 rd_chain;
  logic                 kerr_acc;
  logic [7:0]           lane_byte;
  logic                 lane_is_k;
  logic [11:0]          lane_res;

`ifdef ENC8B10B_KCHAR_EN
  assign lane_k = head_k;
`else
  assign lane_k = '0;
`endif

  // Ripple RD through all lanes in one cycle. An empty buffer feeds K28.5 (0xBC) to every lane.
  always_comb begin
    rd_chain  = rd;
    kerr_acc  = 1'b0;
    enc_code  = '0;
    lane_byte = 8'h00;
    lane_is_k = 1'b0;
    lane_res  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (empty) begin
        lane_byte = 8'hBC;
        lane_is_k = 1'b1;
      end else begin
        lane_byte = head_data[8*i +: 8];
        lane_is_k = lane_k[i];
      end
      lane_res             = enc_lane(lane_byte, lane_is_k, rd_chain);
      enc_code[10*i +: 10] = lane_res[9:0];
      rd_chain             = lane_res[10];
      kerr_acc             = kerr_acc | lane_res[11];
    end
    enc_rd   = rd_chain;
    enc_kerr = kerr_acc;
  end

  // ---------------------------------------------------------------------
  // Output registers: load on the serializer strobe, hold otherwise
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out    <= '0;
      idle_out <= 1'b0;
      rd       <= 1'b0;
    end else if (nextword_enable) begin
      d_out    <= enc_code;
      idle_out <= empty;
      rd       <= enc_rd;
    end
  end

  assign rd_out = rd;

`ifdef ENC8B10B_KCHAR_EN
  // Invalid-K flag for the word currently on d_out
  always_ff @(posedge clk) begin
    if (rst)                  k_err <= 1'b0;
    else if (nextword_enable) k_err <= enc_kerr;
  end
`else
  assign k_err = 1'b0;
  logic unused_kchar;
  assign unused_kchar = ^{head_k, enc_kerr};
`endif

endmodule

// File: tb/tb_encode_8b10b_lanes.sv
// Directed bench for encode_8b10b_lanes (LANES=2).
// Expected code groups were worked out by hand from the 8b/10b tables.
// Lanes are packed as {lane1, lane0}.
module tb_encode_8b10b_lanes;

  localparam int LANES = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [8*LANES-1:0]  in_data;
  logic [LANES-1:0]    in_k;
  logic                in_valid;
  logic                in_ready;
  logic                nextword_enable;
  logic [10*LANES-1:0] d_out;
  logic                idle_out;
  logic                k_err;
  logic                rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10*LANES-1:0] exp_q[$];

  encode_8b10b_lanes #(.LANES(LANES)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_k            (in_k),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .nextword_enable (nextword_enable),
    .d_out           (d_out),
    .idle_out        (idle_out),
    .k_err           (k_err),
    .rd_out          (rd_out)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait, with a bound, until it is accepted
  task automatic push_word(input string tag, input logic [15:0] data, input logic [1:0] k);
    logic done;
    done     = 1'b0;
    in_data  = data;
    in_k     = k;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!done) begin
        if (in_ready) done = 1'b1;
        tick();
      end
    end
    in_valid = 1'b0;
    in_k     = '0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no accept expected in_ready within 20 cycles", tag);
    end
  endtask

  // One serializer pull, then compare against the scoreboard head
  task automatic strobe(input string tag, input logic exp_idle, input logic exp_rd);
    nextword_enable = 1'b1;
    tick();
    nextword_enable = 1'b0;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got empty scoreboard expected a queued word", tag);
    end else begin
      check(tag, d_out, exp_q.pop_front());
    end
    check({tag, "_idle"}, idle_out, exp_idle);
    check({tag, "_rd"}, rd_out, exp_rd);
  endtask

  initial begin
    rst             = 1'b1;
    in_data         = '0;
    in_k            = '0;
    in_valid        = 1'b0;
    nextword_enable = 1'b0;
    tick();
    tick();
    check("rst_d_out", d_out, 20'h0);
    check("rst_idle", idle_out, 1'b0);
    check("rst_kerr", k_err, 1'b0);
    check("rst_rd", rd_out, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Idle word from RD-
    exp_q.push_back({10'h283, 10'h17C});
    strobe("idle_rdm", 1'b1, 1'b0);
    check("idle_rdm_kerr", k_err, 1'b0);

    // D.0.0 on both lanes
    push_word("push_d00", 16'h0000, 2'b00);
    exp_q.push_back({10'h0B9, 10'h0B9});
    strobe("d00", 1'b0, 1'b0);

    // Fill the buffer, stall a third word, then drain in order
    push_word("push_a", 16'hF1BC, 2'b00);   // D.28.5, D.17.7(A7 at RD-)
    push_word("push_b", 16'h00EB, 2'b00);   // D.11.7(A7 at RD+), D.0.0
    check("full_ready", in_ready, 1'b0);
    in_data  = 16'h63E1;                    // D.1.7(P7), D.3.3
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    check("stall_ready", in_ready, 1'b0);
    check("hold_d_out", d_out, {10'h0B9, 10'h0B9});
    exp_q.push_back({10'h3B1, 10'h15C});
    exp_q.push_back({10'h0B9, 10'h04B});
    exp_q.push_back({10'h0E3, 10'h22E});
    exp_q.push_back({10'h283, 10'h17C});
    strobe("word_a", 1'b0, 1'b1);
    check("ready_after_pop", in_ready, 1'b1);
    tick();                                  // stalled word goes in here
    in_valid = 1'b0;
    check("refull_ready", in_ready, 1'b0);
    strobe("word_b", 1'b0, 1'b0);
    strobe("word_c", 1'b0, 1'b0);
    strobe("idle_after", 1'b1, 1'b0);

    // Push and pop together with one word held
    push_word("push_old", 16'h0000, 2'b00);
    in_data         = 16'hBCF1;
    in_valid        = 1'b1;
    nextword_enable = 1'b1;
    tick();
    in_valid        = 1'b0;
    nextword_enable = 1'b0;
    check("pp_old", d_out, {10'h0B9, 10'h0B9});
    check("pp_ready", in_ready, 1'b1);
    check("pp_rd", rd_out, 1'b0);
    exp_q.push_back({10'h15C, 10'h3B1});
    strobe("pp_new", 1'b0, 1'b1);
    exp_q.push_back({10'h17C, 10'h283});
    strobe("idle_rdp", 1'b1, 1'b1);

    // Reset with a full buffer
    push_word("push_r0", 16'h1234, 2'b00);
    push_word("push_r1", 16'h5678, 2'b00);
    check("pre_rst_ready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_d_out", d_out, 20'h0);
    check("mid_rst_rd", rd_out, 1'b0);
    check("mid_rst_idle", idle_out, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    exp_q.push_back({10'h283, 10'h17C});
    strobe("post_rst_idle", 1'b1, 1'b0);

    // Control characters via in_k
`ifdef ENC8B10B_KCHAR_EN
    push_word("push_k287", 16'h00FC, 2'b01);
    exp_q.push_back({10'h0B9, 10'h07C});
    strobe("k28_7", 1'b0, 1'b0);
    check("k28_7_kerr", k_err, 1'b0);
    push_word("push_kbad", 16'h0000, 2'b01);
    exp_q.push_back({10'h346, 10'h17C});
    strobe("kbad", 1'b0, 1'b1);
    check("kbad_kerr", k_err, 1'b1);
`else
    push_word("push_k287", 16'h00FC, 2'b01);
    exp_q.push_back({10'h346, 10'h1DC});
    strobe("k_ignored", 1'b0, 1'b1);
    check("k_ignored_kerr", k_err, 1'b0);
    push_word("push_kbad", 16'h0000, 2'b01);
    exp_q.push_back({10'h346, 10'h346});
    strobe("kbad_ignored", 1'b0, 1'b1);
    check("kbad_ignored_kerr", k_err, 1'b0);
`endif
    exp_q.push_back({10'h17C, 10'h283});
    strobe("idle_kclr", 1'b1, 1'b1);
    check("idle_kclr_kerr", k_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
